// File: rtl/clock_timebase_pkg.sv
// Shared widths, types and helpers for the clock timebase.
// Imported by the timebase interface, phase divider and top.
package clock_timebase_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int DIV_W_DEF = 16;

  typedef logic [CNT_W_DEF-1:0] cycles_t;
  typedef logic [DIV_W_DEF-1:0] div_t;

  function automatic div_t div_eff(div_t d);
    return (d == '0) ? div_t'(1) : d;
  endfunction

endpackage

// File: rtl/clock_timebase_if.sv
// Timebase bus: en/div in, tick/clk_div/phase/cycles/tick_cnt out.
// master = consumer driving en/div, slave = clock_timebase.
interface clock_timebase_if
  import clock_timebase_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
);

  logic             en;
  logic [DIV_W-1:0] div;
  logic             tick;
  logic             clk_div;
  logic [DIV_W-1:0] phase;
  logic [CNT_W-1:0] cycles;
  logic [CNT_W-1:0] tick_cnt;

  modport master (
    output en, div,
    input  tick, clk_div, phase,
    input  cycles, tick_cnt
  );

  modport slave (
    input  en, div,
    output tick, clk_div, phase,
    output cycles, tick_cnt
  );

endinterface

// File: rtl/clock_phase_div.sv
// Phase divider: phase counter, tick strobe, clk_div enable.
// Ports: clk, rst (sync, high), en, div in; term, tick, clk_div, phase out.
module clock_phase_div
  import clock_timebase_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             term,
  output logic             tick,
  output logic             clk_div,
  output logic [DIV_W-1:0] phase
);

  logic [DIV_W-1:0] div_e;

  always_comb begin
    div_e = (div == '0) ? DIV_W'(1) : div;
  end

  // >= lets a shrunk divisor wrap on the next enabled edge
  assign term = en && (phase >= div_e - DIV_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= '0;
      tick    <= 1'b0;
      clk_div <= 1'b0;
    end else if (term) begin
      phase   <= '0;
      tick    <= 1'b1;
      clk_div <= ~clk_div;
    end else if (en) begin
      phase   <= phase + DIV_W'(1);
      tick    <= 1'b0;
    end else begin
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/clock_timebase.sv
// Central timebase: free-running cycle count, tick and clk_div enables.
// Ports: clk, rst (sync, high), bus (slave). Macro CLOCK_TIMEBASE_STATS_EN adds tick_cnt.
module clock_timebase
  import clock_timebase_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  clock_timebase_if.slave  bus
);

  logic             term;
  logic             tick;
  logic             clk_div;
  logic [DIV_W-1:0] phase;
  logic [CNT_W-1:0] cycles;

  clock_phase_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.en),
    .div     (bus.div),
    .term    (term),
    .tick    (tick),
    .clk_div (clk_div),
    .phase   (phase)
  );

  always_ff @(posedge clk) begin
    if (rst) cycles <= '0;
    else     cycles <= cycles + CNT_W'(1);
  end

`ifdef CLOCK_TIMEBASE_STATS_EN
  logic [CNT_W-1:0] tick_cnt;

  // counts on term so it lands on the same edge tick rises
  always_ff @(posedge clk) begin
    if (rst)       tick_cnt <= '0;
    else if (term) tick_cnt <= tick_cnt + CNT_W'(1);
  end

  assign bus.tick_cnt = tick_cnt;
`else
  logic term_unused;
  assign term_unused  = term;
  assign bus.tick_cnt = '0;
`endif

  assign bus.tick    = tick;
  assign bus.clk_div = clk_div;
  assign bus.phase   = phase;
  assign bus.cycles  = cycles;

endmodule

// File: tb/tb_clock_timebase.sv
// Self-checking bench for clock_timebase (32-bit and 4-bit counter builds).
// Directed scenarios plus randomized run against a behavioural model.
module tb_clock_timebase;

`ifdef CLOCK_TIMEBASE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] div;

  int vectors = 0;
  int errors  = 0;

  // model: unbounded counts, narrowed at compare time
  longint m_cyc;
  longint m_ticks;
  longint m_phase;
  bit     m_tick;

  clock_timebase_if #(.CNT_W(32), .DIV_W(16)) bus ();
  clock_timebase_if #(.CNT_W(4),  .DIV_W(16)) sbus ();

  assign bus.en   = en;
  assign bus.div  = div;
  assign sbus.en  = en;
  assign sbus.div = div;

  clock_timebase #(.CNT_W(32), .DIV_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  clock_timebase #(.CNT_W(4), .DIV_W(16)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  initial clk = 1'b0;
  always #100 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, got no finish, need finish");
    $fatal(1);
  end

  function automatic logic [31:0] exp_tc();
    return STATS ? 32'(m_ticks) : 32'd0;
  endfunction

  function automatic logic [3:0] exp_tc_s();
    return STATS ? 4'(m_ticks) : 4'd0;
  endfunction

  // one rising edge through the model, then settle to the falling edge
  task automatic edge_step();
    longint e;
    @(posedge clk);
    e = (div == 16'd0) ? 1 : longint'(div);
    if (rst) begin
      m_cyc = 0; m_ticks = 0;
      m_phase = 0; m_tick = 0;
    end else begin
      m_cyc++;
      if (en && m_phase + 1 >= e) begin
        m_phase = 0; m_tick = 1; m_ticks++;
      end else begin
        m_tick = 0;
        if (en) m_phase++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'($urandom);
    div = 16'($urandom);
    edge_step();
    edge_step();
    vectors++;
    if ({bus.tick, bus.clk_div, bus.phase, bus.cycles, bus.tick_cnt}
        !== 82'd0) begin
      errors++;
      $display("FAIL reset: got t=%b c=%b p=%0d cy=%0d tc=%0d, need all 0",
               bus.tick, bus.clk_div, bus.phase, bus.cycles, bus.tick_cnt);
    end
    vectors++;
    if ({sbus.tick, sbus.clk_div, sbus.phase, sbus.cycles, sbus.tick_cnt}
        !== 26'd0) begin
      errors++;
      $display("FAIL reset_small: got cy=%0d tc=%0d, need 0",
               sbus.cycles, sbus.tick_cnt);
    end
  endtask

  task automatic test_div4();
    bit ec;
    rst = 1'b0; en = 1'b1; div = 16'd4;
    for (int k = 1; k <= 12; k++) begin
      edge_step();
      ec = (k >= 4 && k <= 7) || (k >= 12);
      vectors++;
      if (bus.tick !== (k % 4 == 0)) begin
        errors++;
        $display("FAIL div4_tick edge %0d: got %b need %b",
                 k, bus.tick, (k % 4 == 0));
      end
      vectors++;
      if (bus.clk_div !== ec) begin
        errors++;
        $display("FAIL div4_clkdiv edge %0d: got %b need %b",
                 k, bus.clk_div, ec);
      end
    end
    vectors++;
    if (bus.cycles !== 32'd12) begin
      errors++;
      $display("FAIL div4_cycles: got %0d need 12", bus.cycles);
    end
    vectors++;
    if (bus.tick_cnt !== (STATS ? 32'd3 : 32'd0)) begin
      errors++;
      $display("FAIL div4_tickcnt: got %0d need %0d",
               bus.tick_cnt, STATS ? 3 : 0);
    end
  endtask

  task automatic test_div_one();
    for (int k = 0; k < 8; k++) begin
      div = (k < 4) ? 16'd0 : 16'd1;
      edge_step();
      vectors++;
      if (bus.tick !== 1'b1 || bus.phase !== 16'd0) begin
        errors++;
        $display("FAIL div1 step %0d: got t=%b p=%0d need t=1 p=0",
                 k, bus.tick, bus.phase);
      end
      vectors++;
      if (bus.clk_div !== m_ticks[0]) begin
        errors++;
        $display("FAIL div1_clkdiv step %0d: got %b need %b",
                 k, bus.clk_div, m_ticks[0]);
      end
    end
  endtask

  task automatic test_en_hold();
    longint c0;
    div = 16'd4; en = 1'b1;
    edge_step();
    edge_step();
    vectors++;
    if (bus.phase !== 16'd2) begin
      errors++;
      $display("FAIL en_setup: got phase %0d need 2", bus.phase);
    end
    c0 = m_cyc;
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      edge_step();
      vectors++;
      if (bus.phase !== 16'd2 || bus.tick !== 1'b0) begin
        errors++;
        $display("FAIL en_hold %0d: got p=%0d t=%b need p=2 t=0",
                 k, bus.phase, bus.tick);
      end
    end
    vectors++;
    if (bus.cycles !== 32'(c0 + 3)) begin
      errors++;
      $display("FAIL en_hold_cycles: got %0d need %0d",
               bus.cycles, c0 + 3);
    end
    en = 1'b1;
    edge_step();
    vectors++;
    if (bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL en_resume1: got tick %b need 0", bus.tick);
    end
    edge_step();
    vectors++;
    if (bus.tick !== 1'b1) begin
      errors++;
      $display("FAIL en_resume2: got tick %b need 1", bus.tick);
    end
  endtask

  task automatic test_div_shrink();
    bit cd0;
    div = 16'd8; en = 1'b1;
    for (int k = 0; k < 5; k++) edge_step();
    vectors++;
    if (bus.phase !== 16'd5) begin
      errors++;
      $display("FAIL shrink_setup: got phase %0d need 5", bus.phase);
    end
    cd0 = m_ticks[0];
    div = 16'd3;
    edge_step();
    vectors++;
    if (bus.phase !== 16'd0 || bus.tick !== 1'b1 || bus.clk_div !== ~cd0)
    begin
      errors++;
      $display("FAIL shrink: got p=%0d t=%b c=%b need p=0 t=1 c=%b",
               bus.phase, bus.tick, bus.clk_div, ~cd0);
    end
  endtask

  task automatic test_wrap_reset();
    rst = 1'b1;
    edge_step();
    rst = 1'b0; en = 1'b1; div = 16'd5;
    for (int k = 1; k <= 17; k++) begin
      edge_step();
      vectors++;
      if (sbus.cycles !== 4'(k)) begin
        errors++;
        $display("FAIL wrap edge %0d: got %0d need %0d",
                 k, sbus.cycles, 4'(k));
      end
      vectors++;
      if (sbus.tick_cnt !== exp_tc_s()) begin
        errors++;
        $display("FAIL wrap_tickcnt edge %0d: got %0d need %0d",
                 k, sbus.tick_cnt, exp_tc_s());
      end
    end
    rst = 1'b1;
    edge_step();
    vectors++;
    if ({bus.tick, bus.clk_div, bus.phase, bus.cycles, bus.tick_cnt,
         sbus.cycles, sbus.tick_cnt} !== 90'd0) begin
      errors++;
      $display("FAIL mid_reset: got cy=%0d p=%0d scy=%0d, need 0",
               bus.cycles, bus.phase, sbus.cycles);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      en  = ($urandom_range(0, 3) != 0);
      div = (k % 50 < 25) ? 16'($urandom_range(0, 6))
                          : 16'($urandom_range(0, 20));
      edge_step();
      vectors++;
      if (bus.tick !== m_tick || bus.phase !== 16'(m_phase) ||
          bus.clk_div !== m_ticks[0]) begin
        errors++;
        $display("FAIL rand_div %0d: got t=%b p=%0d c=%b need t=%b p=%0d c=%b",
                 k, bus.tick, bus.phase, bus.clk_div,
                 m_tick, m_phase, m_ticks[0]);
      end
      vectors++;
      if (bus.cycles !== 32'(m_cyc) || bus.tick_cnt !== exp_tc()) begin
        errors++;
        $display("FAIL rand_cnt %0d: got cy=%0d tc=%0d need cy=%0d tc=%0d",
                 k, bus.cycles, bus.tick_cnt, 32'(m_cyc), exp_tc());
      end
      vectors++;
      if (sbus.cycles !== 4'(m_cyc) || sbus.tick_cnt !== exp_tc_s() ||
          sbus.tick !== m_tick) begin
        errors++;
        $display("FAIL rand_small %0d: got cy=%0d tc=%0d need cy=%0d tc=%0d",
                 k, sbus.cycles, sbus.tick_cnt, 4'(m_cyc), exp_tc_s());
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div = 16'd0;
    m_cyc = 0; m_ticks = 0; m_phase = 0; m_tick = 0;
    test_reset();
    test_div4();
    test_div_one();
    test_en_hold();
    test_div_shrink();
    test_wrap_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
